// File: rtl/coriolis_ker0_join2.sv
// coriolis_ker0_join2: two-lane FIFO join that presents matched operand pairs to the kernel-0 FP adder.
// Ports: clk; rst (async, active-low); lane k: ink_s0 / ivalid_ink_s0 / iready_ink_s0;
// output pair: out1_s0 / out2_s0 / ovalid / oready.
// Optional stall_cnt output when CORIOLIS_JOIN_STALLCNT_EN is defined.
module coriolis_ker0_join2 #(
  parameter int STREAMW = 34,
  parameter int DEPTH = 4,
  parameter int ADDRW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STREAMW-1:0] in1_s0,
  input  logic               ivalid_in1_s0,
  output logic               iready_in1_s0,
  input  logic [STREAMW-1:0] in2_s0,
  input  logic               ivalid_in2_s0,
  output logic               iready_in2_s0,
  output logic [STREAMW-1:0] out1_s0,
  output logic [STREAMW-1:0] out2_s0,
  output logic               ovalid,
  input  logic               oready
`ifdef CORIOLIS_JOIN_STALLCNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);
  localparam logic [ADDRW:0] full_cnt = (ADDRW+1)'(DEPTH);
  logic [STREAMW-1:0] mem_q [2][DEPTH];
  logic [STREAMW-1:0] mem_d [2][DEPTH];
  logic [ADDRW-1:0]   wr_q [2];
  logic [ADDRW-1:0]   wr_d [2];
  logic [ADDRW-1:0]   rd_q [2];
  logic [ADDRW-1:0]   rd_d [2];
  logic [ADDRW:0]     cnt_q [2];
  logic [ADDRW:0]     cnt_d [2];
  logic [1:0]         iready_q, iready_d, push;
  logic               pop;
  assign push[0] = ivalid_in1_s0 & iready_q[0];
  assign push[1] = ivalid_in2_s0 & iready_q[1];
  assign ovalid = (cnt_q[0] != '0) & (cnt_q[1] != '0);
  assign pop = ovalid & oready;
  assign iready_in1_s0 = iready_q[0];
  assign iready_in2_s0 = iready_q[1];
  assign out1_s0 = mem_q[0][rd_q[0]];
  assign out2_s0 = mem_q[1][rd_q[1]];
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 2; k++) begin
      wr_d[k] = push[k] ? wr_q[k] + 1'b1 : wr_q[k];
      rd_d[k] = pop ? rd_q[k] + 1'b1 : rd_q[k];
      cnt_d[k] = (push[k] && !pop) ? cnt_q[k] + 1'b1 :
                 (pop && !push[k]) ? cnt_q[k] - 1'b1 : cnt_q[k];
      // ready is registered from the next count so it never sees oready combinationally
      iready_d[k] = cnt_d[k] != full_cnt;
    end
    if (push[0]) mem_d[0][wr_q[0]] = in1_s0;
    if (push[1]) mem_d[1][wr_q[1]] = in2_s0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_q     <= '{default: '0};
      rd_q     <= '{default: '0};
      cnt_q    <= '{default: '0};
      iready_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      iready_q <= iready_d;
    end
  end
`ifdef CORIOLIS_JOIN_STALLCNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (ovalid && !oready && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_coriolis_ker0_join2.sv
// tb_coriolis_ker0_join2: vector table, directed corner sequences and random traffic against a queue model.
module tb_coriolis_ker0_join2;
  localparam int STREAMW = 34;
  localparam int DEPTH = 4;
  localparam int ADDRW = 2;
  localparam logic [33:0] f1 = 34'h1_3F80_0000, f2 = 34'h1_4000_0000, f3 = 34'h1_4040_0000;
  localparam logic [33:0] f10 = 34'h1_4120_0000, f20 = 34'h1_41A0_0000, f30 = 34'h1_41F0_0000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [STREAMW-1:0] in1_s0 = '0, in2_s0 = '0;
  logic ivalid_in1_s0 = 1'b0, ivalid_in2_s0 = 1'b0, oready = 1'b0;
  logic iready_in1_s0, iready_in2_s0, ovalid;
  logic [STREAMW-1:0] out1_s0, out2_s0;
`ifdef CORIOLIS_JOIN_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif
  coriolis_ker0_join2 #(.STREAMW(STREAMW), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst),
    .in1_s0(in1_s0), .ivalid_in1_s0(ivalid_in1_s0), .iready_in1_s0(iready_in1_s0),
    .in2_s0(in2_s0), .ivalid_in2_s0(ivalid_in2_s0), .iready_in2_s0(iready_in2_s0),
    .out1_s0(out1_s0), .out2_s0(out2_s0), .ovalid(ovalid), .oready(oready)
`ifdef CORIOLIS_JOIN_STALLCNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [33:0] q1[$], q2[$];
  bit m_rdy = 1'b0;
  logic [31:0] m_stall = '0;
  typedef struct {
    bit v1; logic [33:0] d1; bit v2; logic [33:0] d2; bit ordy;
    bit ov; logic [33:0] o1; logic [33:0] o2;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic check_model(input string tag);
    bit ov;
    ov = q1.size() > 0 && q2.size() > 0;
    chk({tag, "_ovalid"}, 64'(ovalid), 64'(ov));
    chk({tag, "_iready1"}, 64'(iready_in1_s0), 64'(m_rdy && q1.size() < DEPTH));
    chk({tag, "_iready2"}, 64'(iready_in2_s0), 64'(m_rdy && q2.size() < DEPTH));
    if (ov) begin
      chk({tag, "_out1"}, 64'(out1_s0), 64'(q1[0]));
      chk({tag, "_out2"}, 64'(out2_s0), 64'(q2[0]));
    end
`ifdef CORIOLIS_JOIN_STALLCNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`endif
  endtask
  // Advance one clock edge, updating the queue model from the inputs present before the edge.
  task automatic tick();
    bit p1, p2, pp, st;
    logic [33:0] d1, d2, junk;
    d1 = in1_s0;
    d2 = in2_s0;
    p1 = rst && ivalid_in1_s0 && m_rdy && q1.size() < DEPTH;
    p2 = rst && ivalid_in2_s0 && m_rdy && q2.size() < DEPTH;
    pp = rst && q1.size() > 0 && q2.size() > 0 && oready;
    st = rst && q1.size() > 0 && q2.size() > 0 && !oready;
    @(posedge clk);
    if (pp) begin
      junk = q1.pop_front();
      junk = q2.pop_front();
    end
    if (p1) q1.push_back(d1);
    if (p2) q2.push_back(d2);
    if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (rst) m_rdy = 1'b1;
    #1;
  endtask
  task automatic idle_inputs();
    ivalid_in1_s0 = 1'b0;
    ivalid_in2_s0 = 1'b0;
    in1_s0 = '0;
    in2_s0 = '0;
    oready = 1'b1;
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    m_rdy = 1'b0;
    m_stall = '0;
    chk({tag, "_rst_ovalid"}, 64'(ovalid), 64'd0);
    chk({tag, "_rst_out1"}, 64'(out1_s0), 64'd0);
    chk({tag, "_rst_out2"}, 64'(out2_s0), 64'd0);
    chk({tag, "_rst_iready"}, 64'({iready_in1_s0, iready_in2_s0}), 64'd0);
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    chk({tag, "_rel_iready_pre"}, 64'({iready_in1_s0, iready_in2_s0}), 64'd0);
    tick();
    chk({tag, "_rel_iready_post"}, 64'({iready_in1_s0, iready_in2_s0}), 64'd3);
    check_model({tag, "_rel"});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [33:0] w1[5], w2[5], a1[16], a2[16];
    int i1, i2, got;
    tbl[0] = '{1'b1, f1, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    tbl[1] = '{1'b1, f2, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    tbl[2] = '{1'b1, f3, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    tbl[3] = '{1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    tbl[4] = '{1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    tbl[5] = '{1'b0, '0, 1'b1, f10, 1'b1, 1'b0, '0, '0};
    tbl[6] = '{1'b0, '0, 1'b1, f20, 1'b1, 1'b1, f1, f10};
    tbl[7] = '{1'b0, '0, 1'b1, f30, 1'b1, 1'b1, f2, f20};
    tbl[8] = '{1'b0, '0, 1'b0, '0, 1'b1, 1'b1, f3, f30};
    tbl[9] = '{1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0};
    @(posedge clk);
    #1;
    do_reset("init");
    for (int i = 0; i < 10; i++) begin
      ivalid_in1_s0 = tbl[i].v1;
      in1_s0 = tbl[i].d1;
      ivalid_in2_s0 = tbl[i].v2;
      in2_s0 = tbl[i].d2;
      oready = tbl[i].ordy;
      chk($sformatf("tbl%0d_ovalid", i), 64'(ovalid), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out1", i), 64'(out1_s0), 64'(tbl[i].o1));
        chk($sformatf("tbl%0d_out2", i), 64'(out2_s0), 64'(tbl[i].o2));
      end
      check_model("tbl");
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      w1[i] = {2'($urandom_range(3)), $urandom};
      w2[i] = {2'($urandom_range(3)), $urandom};
    end
    i1 = 0;
    for (int c = 0; c < 12; c++) begin
      ivalid_in1_s0 = i1 < 5;
      in1_s0 = w1[i1 < 5 ? i1 : 4];
      check_model("fill");
      if (ivalid_in1_s0 && iready_in1_s0) i1++;
      tick();
    end
    chk("fill_iready1", 64'(iready_in1_s0), 64'd0);
    chk("fill_accepted", 64'(i1), 64'd4);
    i2 = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      ivalid_in1_s0 = i1 < 5;
      in1_s0 = w1[i1 < 5 ? i1 : 4];
      ivalid_in2_s0 = i2 < 5;
      in2_s0 = w2[i2 < 5 ? i2 : 4];
      check_model("drain");
      if (ovalid && oready) begin
        chk($sformatf("drain%0d_out1", got), 64'(out1_s0), 64'(w1[got]));
        chk($sformatf("drain%0d_out2", got), 64'(out2_s0), 64'(w2[got]));
        got++;
      end
      if (ivalid_in1_s0 && iready_in1_s0) i1++;
      if (ivalid_in2_s0 && iready_in2_s0) i2++;
      tick();
    end
    chk("drain_pairs", 64'(got), 64'd5);
    idle_inputs();
    tick();
    do_reset("stream");
    for (int i = 0; i < 16; i++) begin
      a1[i] = {2'($urandom_range(3)), $urandom};
      a2[i] = {2'($urandom_range(3)), $urandom};
    end
    i1 = 0;
    i2 = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      oready = !(c >= 6 && c <= 8);
      ivalid_in1_s0 = i1 < 16;
      in1_s0 = a1[i1 < 16 ? i1 : 15];
      ivalid_in2_s0 = i2 < 16;
      in2_s0 = a2[i2 < 16 ? i2 : 15];
      check_model("stream");
      if (ovalid && oready) begin
        chk($sformatf("stream%0d_out1", got), 64'(out1_s0), 64'(a1[got]));
        chk($sformatf("stream%0d_out2", got), 64'(out2_s0), 64'(a2[got]));
        got++;
      end
      if (ivalid_in1_s0 && iready_in1_s0) i1++;
      if (ivalid_in2_s0 && iready_in2_s0) i2++;
      tick();
    end
    chk("stream_pairs", 64'(got), 64'd16);
    chk("stream_ovalid_end", 64'(ovalid), 64'd0);
`ifdef CORIOLIS_JOIN_STALLCNT_EN
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    idle_inputs();
    oready = 1'b0;
    ivalid_in1_s0 = 1'b1;
    ivalid_in2_s0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in1_s0 = 34'(i + 1);
      in2_s0 = 34'(i + 17);
      tick();
    end
    ivalid_in1_s0 = 1'b0;
    ivalid_in2_s0 = 1'b0;
    check_model("async_pre");
    chk("async_pre_ovalid", 64'(ovalid), 64'd1);
    #2;
    do_reset("async");
    for (int c = 0; c < 4; c++) begin
      check_model("async_after");
      tick();
    end
    for (int c = 0; c < 300; c++) begin
      ivalid_in1_s0 = $urandom_range(1);
      ivalid_in2_s0 = $urandom_range(1);
      in1_s0 = {2'($urandom_range(3)), $urandom};
      in2_s0 = {2'($urandom_range(3)), $urandom};
      oready = $urandom_range(9) < 7;
      check_model("rand");
      tick();
    end
    idle_inputs();
    check_model("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
